// File: rtl/cpu_pkg.sv
// Shared CPU definitions: phase codes (consumed by the sequencer and the
// memory-access stage) and the HALT opcode field value.
package cpu_pkg;

  typedef enum logic [2:0] {
    PH_FETCH  = 3'b000,
    PH_DECODE = 3'b100,
    PH_EXEC   = 3'b010,
    PH_MEM    = 3'b001,
    PH_WB     = 3'b011,
    PH_IDLE   = 3'b110,
    PH_HALT   = 3'b111
  } phase_e;

  localparam logic [4:0] HALT_OP = 5'b11111;

  function automatic logic is_halt(input logic [15:0] ins);
    return ins[15:11] == HALT_OP;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register and next-pc selection.
//   clk, rst_n     : clock, async active-low reset (pc -> 0)
//   advance        : update pc this cycle (end of a non-halting WB)
//   branch_taken   : select branch_target instead of pc+1
//   branch_target  : branch destination
//   pc             : program counter
module pc_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [11:0] branch_target,
  output logic [11:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= '0;
    else if (advance)
      pc <= branch_taken ? branch_target : pc + 12'd1;  // 4095 wraps to 0
  end

endmodule

// File: rtl/phase_seq.sv
// Instruction phase sequencer: IDLE -> FETCH/DECODE/EXEC/MEM/WB loop, HALT on
// the halt opcode. Phase code is the state register itself.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin/resume from IDLE or HALT
//   stall           : freeze phase and all registers (no effect in IDLE/HALT)
//   mem_q           : memory read data, captured into instr at end of DECODE
//   branch_taken    : branch decision, used only at end of WB
//   branch_target   : next pc on a taken branch
//   phase           : current phase code
//   pc, instr       : program counter, instruction register
//   halted          : high while in HALT
//   retired         : completed instruction count
module phase_seq
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [15:0] mem_q,
  input  logic        branch_taken,
  input  logic [11:0] branch_target,
  output logic [2:0]  phase,
  output logic [11:0] pc,
  output logic [15:0] instr,
  output logic        halted,
  output logic [15:0] retired
);

  phase_e st;
  logic   wb_done;
  logic   advance;

  assign wb_done = (st == PH_WB) && !stall;
  // A halting instruction leaves pc untouched and ignores the branch.
  assign advance = wb_done && !is_halt(instr);
  assign phase   = st;

  pc_unit u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= PH_IDLE;
      instr   <= '0;
      retired <= '0;
      halted  <= 1'b0;
    end else begin
      case (st)
        PH_IDLE, PH_HALT: begin
          if (start) begin
            st     <= PH_FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          if (!stall) begin
            case (st)
              PH_FETCH:  st <= PH_DECODE;
              PH_DECODE: begin
                st    <= PH_EXEC;
                instr <= mem_q;
              end
              PH_EXEC:   st <= PH_MEM;
              PH_MEM:    st <= PH_WB;
              PH_WB: begin
                retired <= retired + 16'd1;
                if (is_halt(instr)) begin
                  st     <= PH_HALT;
                  halted <= 1'b1;
                end else begin
                  st <= PH_FETCH;
                end
              end
              default:   st <= PH_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq.sv
module tb_phase_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] mem_q = '0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = '0;
  logic [2:0]  phase;
  logic [11:0] pc;
  logic [15:0] instr;
  logic        halted;
  logic [15:0] retired;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: mode 0=idle 1=running 2=halted; k = position in the
  // five-step instruction cycle.
  int          m_mode = 0;
  int          m_k = 0;
  int          m_pc = 0;
  int          m_instr = 0;
  int          m_ret = 0;
  logic [2:0]  run_code [5] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b011};

  phase_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .mem_q         (mem_q),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .phase         (phase),
    .pc            (pc),
    .instr         (instr),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_pc = 0; m_instr = 0; m_ret = 0;
  endtask

  task automatic model_edge();
    if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_k = 0; end
    end else if (!stall) begin
      if (m_k == 1) m_instr = mem_q;
      if (m_k == 4) begin
        m_ret = (m_ret + 1) % 65536;
        if ((m_instr >> 11) == 31) m_mode = 2;
        else begin
          m_pc = branch_taken ? int'(branch_target) : (m_pc + 1) % 4096;
          m_k = 0;
        end
      end else m_k++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] ep;
    ep = (m_mode == 0) ? 3'b110 : (m_mode == 2) ? 3'b111 : run_code[m_k];
    chk({tag, ".phase"},   {13'd0, phase}, {13'd0, ep});
    chk({tag, ".pc"},      {4'd0, pc}, 16'(m_pc));
    chk({tag, ".instr"},   instr, 16'(m_instr));
    chk({tag, ".halted"},  {15'd0, halted}, {15'd0, (m_mode == 2)});
    chk({tag, ".retired"}, retired, 16'(m_ret));
  endtask

  task automatic step(input string tag, input logic s, input logic sl,
                      input logic [15:0] mq, input logic bt, input logic [11:0] tg);
    start = s; stall = sl; mem_q = mq; branch_taken = bt; branch_target = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // One instruction from FETCH: optional branch inputs in EXEC (must be
  // ignored) and in WB, optional stall cycles in MEM.
  task automatic run_instr(input string tag, input logic [15:0] mq,
                           input logic bt_exec, input logic bt_wb,
                           input logic [11:0] tg, input int mem_stalls);
    step({tag, ".f"}, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000);
    step({tag, ".d"}, 1'b0, 1'b0, mq, 1'b0, 12'h000);
    step({tag, ".e"}, 1'b0, 1'b0, 16'h0000, bt_exec, tg);
    for (int i = 0; i < mem_stalls; i++)
      step({tag, ".ms"}, 1'b1, 1'b1, 16'hFFFF, 1'b1, 12'hABC);
    step({tag, ".m"}, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000);
    step({tag, ".w"}, 1'b0, 1'b0, 16'h0000, bt_wb, tg);
  endtask

  initial begin
    logic [15:0] rq;
    #12;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    #4;  // now 1 after the posedge at 15
    step("idle_hold", 1'b0, 1'b0, 16'h0, 1'b0, 12'h0);
    step("idle_stall", 1'b0, 1'b1, 16'h0, 1'b0, 12'h0);

    // Basic instruction
    step("go", 1'b1, 1'b0, 16'h0, 1'b0, 12'h0);
    run_instr("basic", 16'h1234, 1'b0, 1'b0, 12'h0, 0);
    chk("basic.pc1", {4'd0, pc}, 16'd1);
    chk("basic.instr", instr, 16'h1234);

    // Branch ignored in EXEC, taken in WB
    run_instr("br", 16'h2222, 1'b1, 1'b1, 12'h0A5, 0);
    chk("br.pc", {4'd0, pc}, 16'h00A5);

    // Stall in MEM for 3 cycles
    run_instr("stall", 16'h0BCD, 1'b0, 1'b0, 12'h0, 3);

    // pc wrap
    run_instr("to_fff", 16'h0001, 1'b0, 1'b1, 12'hFFF, 0);
    run_instr("wrap", 16'h0002, 1'b0, 1'b0, 12'h0, 0);
    chk("wrap.pc0", {4'd0, pc}, 16'd0);

    // Halt instruction, branch must be ignored
    run_instr("halt", 16'hF800, 1'b0, 1'b1, 12'h777, 0);
    chk("halt.halted", {15'd0, halted}, 16'd1);
    step("halt_hold", 1'b0, 1'b1, 16'h0, 1'b0, 12'h0);
    step("halt_go", 1'b1, 1'b1, 16'h0, 1'b0, 12'h0);

    // Reset mid-EXEC, between clock edges
    step("rs.d", 1'b0, 1'b0, 16'h4321, 1'b0, 12'h0);
    step("rs.e", 1'b0, 1'b0, 16'h0, 1'b0, 12'h0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b0, 16'h0, 1'b0, 12'h0);
    step("post_rst_go", 1'b1, 1'b0, 16'h0, 1'b0, 12'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rq = 16'($urandom);
      if ($urandom_range(0, 15) == 0) rq[15:11] = 5'b11111;
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           rq, 1'($urandom), 12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port start, input, 1 bit: begin or resume execution from IDLE/HALT.
REQ-004 SHALL have port stall, input, 1 bit: hold the current phase and all registers.
REQ-005 SHALL have port mem_q, input, 16 bits: memory read data, valid the cycle after the address is presented.
REQ-006 SHALL have port branch_taken, input, 1 bit: execute-unit branch decision, sampled in WB only.
REQ-007 SHALL have port branch_target, input, 12 bits: next pc when branch_taken.
REQ-008 SHALL have port phase, output, 3 bits: current phase code, consumed by the memory-access stage.
REQ-009 SHALL have port pc, output, 12 bits: program counter.
REQ-010 SHALL have port instr, output, 16 bits: instruction register.
REQ-011 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-012 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-013 SHALL implement states/phase codes IDLE=3'b110, FETCH=3'b000, DECODE=3'b100, EXEC=3'b010, MEM=3'b001, WB=3'b011, HALT=3'b111; phase output equals the state code, registered.
REQ-014 SHALL move IDLE->FETCH on start=1; otherwise remain in IDLE.
REQ-015 SHALL sequence FETCH->DECODE->EXEC->MEM->WB->FETCH, one state per cycle when stall=0.
REQ-016 SHALL, when stall=1 in any non-IDLE/HALT state, hold state, pc, instr and retired unchanged.
REQ-017 SHALL capture mem_q into instr at the end of DECODE (stall=0); instr is held in every other state.
REQ-018 SHALL, at the end of WB (stall=0), load pc with branch_target if branch_taken=1, else pc+1 modulo 4096 (4095 wraps to 0).
REQ-019 SHALL increment retired by 1 modulo 65536 at the end of each WB with stall=0.
REQ-020 SHALL treat instr[15:11]=5'b11111 as HALT: at the end of WB go to HALT instead of FETCH, leave pc unchanged, and still increment retired.
REQ-021 SHALL ignore branch_taken for a halting instruction.
REQ-022 SHALL drive halted=1 exactly while in HALT; start=1 in HALT moves to FETCH with pc unchanged (re-executes the halt unless pc was changed by reset).
REQ-023 SHALL ignore start in every state except IDLE and HALT.
REQ-024 SHALL ignore branch_taken and branch_target outside WB.
REQ-025 SHALL give stall no effect in IDLE and HALT; start wins there.

Reset
REQ-026 SHALL, on rst_n=0 and independent of clk, force state IDLE (phase=3'b110), pc=0, instr=0, retired=0, halted=0.
REQ-027 SHALL, on reset in any phase, abandon the instruction in flight with no pc or retired update.
REQ-028 SHALL, after rst_n deasserts, stay in IDLE until start.

Structure
REQ-029 SHALL take the seven phase codes and the HALT opcode field value (5'b11111) from a shared package, cpu_pkg, used also by the memory-access stage.
REQ-030 SHALL place pc next-value selection and the pc register in one sub-module, pc_unit (inputs: advance, branch_taken, branch_target; output: pc).

Verification
REQ-031 Scenario: reset, start pulse, mem_q=16'h1234, no stall -> phases 000,100,010,001,011,000; instr=16'h1234 after DECODE; pc=1, retired=1 after WB.
REQ-032 Scenario: pc=4095 at WB, branch_taken=0 -> pc=0.
REQ-033 Scenario: branch_taken=1, branch_target=12'h0A5 in WB -> pc=12'h0A5; the same inputs in EXEC -> no effect.
REQ-034 Scenario: stall=1 for 3 cycles in MEM -> phase stays 3'b001 for 4 cycles total; pc and instr unchanged.
REQ-035 Scenario: mem_q=16'hF800 fetched -> after WB phase=3'b111, halted=1, pc unchanged, retired+1; start -> FETCH.
REQ-036 Scenario: rst_n pulsed low mid-EXEC between clock edges -> phase=3'b110, pc=0, instr=0, retired=0 immediately.
